wresp_arb_subo: RTL
===================

WRESP_ARB_SUBO -- requirements
Module: wresp_arb_subo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pending-response queue entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port fin0_valid  input  1  requester 0 write-complete request.
REQ-005 SHALL have port fin0_id  input  4  requester 0 transaction ID.
REQ-006 SHALL have port fin0_ack  output  1  requester 0 request accepted this cycle.
REQ-007 SHALL have port fin1_valid  input  1  requester 1 write-complete request.
REQ-008 SHALL have port fin1_id  input  4  requester 1 transaction ID.
REQ-009 SHALL have port fin1_ack  output  1  requester 1 request accepted this cycle.
REQ-010 SHALL have port bvalid  output  1  write-response valid to manager.
REQ-011 SHALL have port bready  input  1  manager accepts response.
REQ-012 SHALL have port bid  output  4  ID of response at queue head.
REQ-013 SHALL have port bcomp  output  1  completion status, constant 1.

Function
REQ-014 SHALL hold an in-order FIFO of DEPTH 4-bit IDs with write pointer, read pointer (log2(DEPTH) bits, wrap modulo DEPTH) and count (0..DEPTH, log2(DEPTH)+1 bits).
REQ-015 SHALL define pop = bvalid & bready; push_ok = (count < DEPTH) | pop.
REQ-016 SHALL accept at most one requester per cycle: finN_ack = finN_valid & grantN & push_ok, combinational.
REQ-017 SHALL grant the sole valid requester when only one is valid; when both valid, grant the requester indicated by 1-bit priority register prio (0 = requester 0).
REQ-018 SHALL update prio on each accepted request to point at the non-accepted requester; prio unchanged when no acceptance.
REQ-019 SHALL, on acceptance, write the accepted finN_id at write pointer and advance write pointer.
REQ-020 SHALL drive bvalid = (count != 0) and bid = entry at read pointer, both from registered state only (no combinational path from fin inputs or bready).
REQ-021 SHALL, on pop, advance read pointer; bid then shows next entry.
REQ-022 SHALL, latency: request accepted in cycle N with empty queue -> bvalid=1, bid=that ID in cycle N+1.
REQ-023 SHALL hold bvalid and bid stable while bvalid=1 and bready=0.
REQ-024 SHALL, push and pop same cycle, leave count unchanged; when count=DEPTH this is permitted (push_ok=1) and the new entry occupies the slot freed.
REQ-025 SHALL, when count=DEPTH and no pop, deassert both acks; requesters hold valid/id until ack.
REQ-026 SHALL ignore bready when bvalid=0 (no pointer/count change).
REQ-027 SHALL drive bcomp = 1 at all times, including during reset.

Reset
REQ-028 SHALL on rst_n=0, asynchronously: pointers 0, count 0, prio 0, all FIFO entries 0; thus bvalid=0, bid=0, acks follow REQ-016 with queue empty.
REQ-029 SHALL, reset mid-operation, discard all queued responses; no bvalid until a new acceptance after rst_n rises.

Verification
REQ-030 SHALL cover single request: fin0_valid=1, fin0_id=5 one cycle, bready=1 -> fin0_ack same cycle, next cycle bvalid=1, bid=5, then bvalid=0.
REQ-031 SHALL cover contention: both valid continuously, fin0_id=1, fin1_id=2, bready=1 -> acks alternate 0,1,0,1; bid sequence 1,2,1,2.
REQ-032 SHALL cover full: bready=0, DEPTH=4, push IDs 3,4,6,7 -> count=4, fifth request gets no ack; set bready=1 -> same-cycle pop and push, bid order 3,4,6,7 then fifth ID.
REQ-033 SHALL cover backpressure: bvalid=1, bid=9, bready=0 for 5 cycles -> bvalid/bid stable; bready=1 one cycle -> single pop.
REQ-034 SHALL cover wrap-around: 10 sequential push/pop of IDs 0..9 at DEPTH=4 -> bid order 0..9, no loss or duplication.
REQ-035 SHALL cover reset mid-operation: 3 entries queued, pulse rst_n low -> bvalid=0, bid=0 immediately, prio=0 (requester 0 wins next contention).

Source files
------------

// File: rtl/wresp_arb_subo.sv
// Two-requester write-response arbiter. Accepted IDs are queued in order and
// returned to the manager on the B channel (valid/ready style).
module wresp_arb_subo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fin0_valid,
  input  logic [3:0] fin0_id,
  output logic       fin0_ack,
  input  logic       fin1_valid,
  input  logic [3:0] fin1_id,
  output logic       fin1_ack,
  output logic       bvalid,
  input  logic       bready,
  output logic [3:0] bid,
  output logic       bcomp
);
  // Handshakes: a B beat transfers when bvalid & bready are high at a rising
  // edge; a requester is accepted in any cycle its ack is high, and must hold
  // valid/id stable until then.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_prio;

  logic       w_pop;
  logic       w_push_ok;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_push;
  logic [3:0] w_push_id;

  assign w_pop     = bvalid & bready;
  assign w_push_ok = (r_count != FULL_CNT) | w_pop;

  // Priority only matters when both requesters are valid.
  assign w_grant0 = fin0_valid & (~fin1_valid | ~r_prio);
  assign w_grant1 = fin1_valid & (~fin0_valid |  r_prio);

  assign fin0_ack  = w_grant0 & w_push_ok;
  assign fin1_ack  = w_grant1 & w_push_ok;
  assign w_push    = fin0_ack | fin1_ack;
  assign w_push_id = fin0_ack ? fin0_id : fin1_id;

  assign bvalid = (r_count != '0);
  assign bid    = r_mem[r_rptr];
  assign bcomp  = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 4'd0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_prio  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_push_id;
        r_wptr        <= r_wptr + AW'(1);
        r_prio        <= fin0_ack;
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end
endmodule
